// File: rtl/shared_pkg.sv
// Shared SPI command encoding and frame sizing for the SPI master controller.
package shared_pkg;

    localparam int unsigned MEM_WIDTH = 8;
    localparam int unsigned CMD_W     = 2;
    localparam int unsigned FRAME_LEN = CMD_W + MEM_WIDTH;
    localparam int unsigned CNT_W     = 4;

    typedef enum logic [CMD_W-1:0] {
        CMD_WR_ADDR = 2'b00,
        CMD_WR_DATA = 2'b01,
        CMD_RD_ADDR = 2'b10,
        CMD_RD_DATA = 2'b11
    } spi_cmd_e;

endpackage

// File: rtl/spi_shift_reg.sv
// Parallel-load / serial-in shift register, MSB shifted out first.
module spi_shift_reg #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift,
    input  logic             serial_in,
    output logic             serial_out,
    output logic [WIDTH-1:0] parallel_out
);

    logic [WIDTH-1:0] sr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q <= '0;
        end else if (load) begin
            sr_q <= load_data;
        end else if (shift) begin
            sr_q <= {sr_q[WIDTH-2:0], serial_in};
        end
    end

    assign serial_out   = sr_q[WIDTH-1];
    assign parallel_out = sr_q;

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI master: sends a {cmd, byte} frame MSB first and, for RD_DATA,
// receives one byte after a fixed turnaround.
module spi_master_ctrl #(
    parameter int unsigned MEM_WIDTH  = shared_pkg::MEM_WIDTH,
    parameter int unsigned TURNAROUND = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [shared_pkg::CMD_W-1:0] cmd,
    input  logic [MEM_WIDTH-1:0]       data_in,
    input  logic                       MISO,
    output logic                       MOSI,
    output logic                       SS_n,
    output logic                       busy,
    output logic [MEM_WIDTH-1:0]       rd_data,
    output logic                       rd_valid,
    output logic                       done
);

    import shared_pkg::*;

    localparam int unsigned FRAME_W = CMD_W + MEM_WIDTH;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SEND = 3'd1,
        ST_WAIT = 3'd2,
        ST_RECV = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    state_e             state;
    logic [CNT_W-1:0]   bit_cnt;
    logic               rd_txn;

    logic               frame_load_c;
    logic               frame_shift_c;
    logic               rx_shift_c;
    logic               frame_msb;
    logic [FRAME_W-1:0] frame_par;
    logic               rx_so;
    logic [MEM_WIDTH-1:0] rx_q;
    logic               unused_bits;

    assign frame_load_c  = (state == ST_IDLE) && start;
    assign frame_shift_c = (state == ST_SEND) && (bit_cnt != '0);
    assign rx_shift_c    = (state == ST_RECV);

    // Frame MSB goes straight to MOSI on accept, so the register is loaded pre-shifted.
    spi_shift_reg #(.WIDTH(FRAME_W)) u_frame_sr (
        .clk          (clk),
        .rst_n        (rst_n),
        .load         (frame_load_c),
        .load_data    ({cmd[0], data_in, 1'b0}),
        .shift        (frame_shift_c),
        .serial_in    (1'b0),
        .serial_out   (frame_msb),
        .parallel_out (frame_par)
    );

    spi_shift_reg #(.WIDTH(MEM_WIDTH)) u_rx_sr (
        .clk          (clk),
        .rst_n        (rst_n),
        .load         (1'b0),
        .load_data    ('0),
        .shift        (rx_shift_c),
        .serial_in    (MISO),
        .serial_out   (rx_so),
        .parallel_out (rx_q)
    );

    assign unused_bits = ^{frame_par, rx_so, rx_q[MEM_WIDTH-1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            bit_cnt  <= '0;
            rd_txn   <= 1'b0;
            MOSI     <= 1'b0;
            SS_n     <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            done     <= 1'b0;
            rd_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state   <= ST_SEND;
                        SS_n    <= 1'b0;
                        MOSI    <= cmd[1];
                        busy    <= 1'b1;
                        bit_cnt <= CNT_W'(FRAME_W - 1);
                        rd_txn  <= (spi_cmd_e'(cmd) == CMD_RD_DATA);
                    end
                end
                ST_SEND: begin
                    if (bit_cnt != '0) begin
                        MOSI    <= frame_msb;
                        bit_cnt <= bit_cnt - CNT_W'(1);
                    end else if (rd_txn) begin
                        MOSI <= 1'b0;
                        if (TURNAROUND == 0) begin
                            state   <= ST_RECV;
                            bit_cnt <= CNT_W'(MEM_WIDTH - 1);
                        end else begin
                            state   <= ST_WAIT;
                            bit_cnt <= CNT_W'(TURNAROUND - 1);
                        end
                    end else begin
                        state   <= ST_DONE;
                        SS_n    <= 1'b1;
                        MOSI    <= 1'b0;
                        done    <= 1'b1;
                        bit_cnt <= '0;
                    end
                end
                ST_WAIT: begin
                    if (bit_cnt != '0) begin
                        bit_cnt <= bit_cnt - CNT_W'(1);
                    end else begin
                        state   <= ST_RECV;
                        bit_cnt <= CNT_W'(MEM_WIDTH - 1);
                    end
                end
                ST_RECV: begin
                    if (bit_cnt != '0) begin
                        bit_cnt <= bit_cnt - CNT_W'(1);
                    end else begin
                        // Last MISO bit is merged directly so rd_data is ready in the done cycle.
                        state    <= ST_DONE;
                        SS_n     <= 1'b1;
                        done     <= 1'b1;
                        rd_valid <= 1'b1;
                        rd_data  <= {rx_q[MEM_WIDTH-2:0], MISO};
                        bit_cnt  <= '0;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    SS_n  <= 1'b1;
                    MOSI  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Scoreboarded bench for spi_master_ctrl with an SPI slave holding a small RAM.
module tb_spi_master_ctrl;

    localparam int unsigned W     = 8;
    localparam int unsigned T     = 2;
    localparam int unsigned FRAME = 10;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   cmd = 2'b00;
    logic [W-1:0] data_in = '0;
    logic         miso = 1'b0;
    logic         mosi, ss_n, busy, rd_valid, done;
    logic [W-1:0] rd_data;

    spi_master_ctrl #(.MEM_WIDTH(W), .TURNAROUND(T)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .cmd      (cmd),
        .data_in  (data_in),
        .MISO     (miso),
        .MOSI     (mosi),
        .SS_n     (ss_n),
        .busy     (busy),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .done     (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [FRAME-1:0] frame;
        bit               is_rd;
        logic [W-1:0]     rd_data;
        int               start_cyc;
        int               lat;
        int               ss_low;
    } exp_t;

    exp_t sb[$];

    // Reference model: transaction-level view of the slave memory
    logic [W-1:0] m_mem [256];
    logic [W-1:0] m_wa, m_ra, m_last;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic issue(input logic [1:0] c, input logic [W-1:0] d, input bit early);
        exp_t e;
        int   w;
        w = 0;
        if (early) begin
            while (!done && w < 200) begin @(posedge clk); #1; w++; end
            chk("wait_done_timeout", 32'(w >= 200), 0);
            start = 1'b1; cmd = c; data_in = d;
            @(posedge clk); #1;
            chk("idle_gap_busy", 32'(busy), 0);
            chk("idle_gap_ss_n", 32'(ss_n), 1);
        end else begin
            while (busy && w < 200) begin @(posedge clk); #1; w++; end
            chk("wait_idle_timeout", 32'(w >= 200), 0);
            start = 1'b1; cmd = c; data_in = d;
        end
        e.start_cyc = cyc;
        e.frame     = {c, d};
        e.is_rd     = (c == 2'b11);
        case (c)
            2'b00: m_wa = d;
            2'b01: m_mem[m_wa] = d;
            2'b10: m_ra = d;
            default: m_last = m_mem[m_ra];
        endcase
        e.rd_data = m_last;
        e.lat     = e.is_rd ? int'(2 + FRAME + T + W) : int'(2 + FRAME);
        e.ss_low  = e.is_rd ? int'(FRAME + T + W) : int'(FRAME);
        sb.push_back(e);
        @(posedge clk); #1;
        start = 1'b0; cmd = 2'($urandom); data_in = W'($urandom);
        chk("busy_after_accept", 32'(busy), 1);
    endtask

    task automatic abort_frame();
        int w;
        w = 0;
        while (busy && w < 200) begin @(posedge clk); #1; w++; end
        chk("abort_wait_timeout", 32'(w >= 200), 0);
        start = 1'b1; cmd = 2'b01; data_in = W'($urandom);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        chk("abort_pre_ss_n", 32'(ss_n), 0);
        rst_n = 1'b0;
        #1;
        chk("abort_ss_n", 32'(ss_n), 1);
        chk("abort_mosi", 32'(mosi), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_rd_data", 32'(rd_data), 0);
        m_last = '0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // Monitor + SPI slave with RAM; pops the scoreboard on every done/rd_valid
    initial begin : monitor
        int               ss_cnt;
        logic [FRAME-1:0] cap;
        bit               mosi_bad;
        bit               s_rd;
        logic [W-1:0]     s_resp, s_wa, s_ra;
        logic [W-1:0]     s_mem [256];
        exp_t             e;
        ss_cnt = 0; cap = '0; mosi_bad = 0; s_rd = 0; s_resp = '0; s_wa = '0; s_ra = '0;
        for (int i = 0; i < 256; i++) s_mem[i] = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                ss_cnt = 0; cap = '0; mosi_bad = 0; s_rd = 0; miso = 1'b0;
            end else begin
                if (!ss_n) begin
                    ss_cnt++;
                    if (ss_cnt == 1) s_rd = 0;
                    if (ss_cnt <= int'(FRAME)) cap = {cap[FRAME-2:0], mosi};
                    else if (mosi) mosi_bad = 1;
                    if (ss_cnt == int'(FRAME)) begin
                        case (cap[FRAME-1:FRAME-2])
                            2'b00: s_wa = cap[W-1:0];
                            2'b01: s_mem[s_wa] = cap[W-1:0];
                            2'b10: s_ra = cap[W-1:0];
                            default: begin s_rd = 1; s_resp = s_mem[s_ra]; end
                        endcase
                    end
                end
                if (!ss_n && s_rd && ss_cnt >= int'(FRAME + T + 1) && ss_cnt <= int'(FRAME + T + W))
                    miso = s_resp[int'(FRAME + T + W) - ss_cnt];
                else
                    miso = 1'($urandom);
                if (done || rd_valid) begin
                    if (sb.size() == 0) begin
                        n_chk++; n_fail++;
                        $display("FAIL unexpected_done: got done=%0b rd_valid=%0b expected no pulse", done, rd_valid);
                    end else begin
                        e = sb.pop_front();
                        chk("frame_bits", 32'(cap), 32'(e.frame));
                        chk("latency", 32'(cyc - e.start_cyc + 1), 32'(e.lat));
                        chk("ss_n_low_cycles", 32'(ss_cnt), 32'(e.ss_low));
                        chk("mosi_idle_zero", 32'(mosi_bad), 0);
                        chk("done_pulse", 32'(done), 1);
                        chk("rd_valid", 32'(rd_valid), 32'(e.is_rd));
                        chk("rd_data", 32'(rd_data), 32'(e.rd_data));
                    end
                    ss_cnt = 0; cap = '0; mosi_bad = 0; s_rd = 0;
                end
            end
        end
    end

    initial begin : driver
        int w;
        for (int i = 0; i < 256; i++) m_mem[i] = '0;
        m_wa = '0; m_ra = '0; m_last = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ss_n", 32'(ss_n), 1);
        chk("reset_mosi", 32'(mosi), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_rd_data", 32'(rd_data), 0);
        chk("reset_done", 32'(done), 0);
        chk("reset_rd_valid", 32'(rd_valid), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        issue(2'b00, 8'h5A, 0);
        issue(2'b00, 8'h10, 0);
        issue(2'b01, 8'hA5, 0);
        issue(2'b10, 8'h10, 0);
        issue(2'b11, 8'h00, 0);
        issue(2'b00, 8'h33, 0);
        issue(2'b01, 8'hC3, 1);
        issue(2'b10, 8'h33, 1);
        issue(2'b11, 8'h5E, 0);

        // Start while busy must be ignored
        issue(2'b00, 8'h22, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("busy_mid_frame", 32'(busy), 1);
        start = 1'b1; cmd = 2'b01; data_in = 8'h77;
        @(posedge clk); #1;
        start = 1'b0;

        abort_frame();
        issue(2'b01, 8'hFF, 0);
        issue(2'b10, m_wa, 0);
        issue(2'b11, W'($urandom), 0);

        for (int k = 0; k < 40; k++)
            issue(2'($urandom), W'($urandom), $urandom_range(0, 3) == 0);

        w = 0;
        while (sb.size() != 0 && w < 500) begin @(posedge clk); #1; w++; end
        chk("scoreboard_drain", 32'(sb.size()), 0);
        repeat (5) @(posedge clk);
        #1;
        chk("final_idle_busy", 32'(busy), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_master_ctrl.md
SPI_MASTER_CTRL -- requirements
Module: spi_master_ctrl

Interface
REQ-001 Parameter MEM_WIDTH, default 8: data byte width.
REQ-002 Parameter TURNAROUND, default 2: clk cycles between the last MOSI bit of a READ_DATA frame and the first MISO sample.
REQ-003 clk  input  1  single system clock; all logic is on its rising edge; also the SPI serial clock seen by the slave.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request strobe; accepted only when busy=0.
REQ-006 cmd  input  2  command: 00 WR_ADDR, 01 WR_DATA, 10 RD_ADDR, 11 RD_DATA.
REQ-007 data_in  input  MEM_WIDTH  address or data byte for the frame.
REQ-008 MISO  input  1  serial data from the slave.
REQ-009 MOSI  output  1  serial data to the slave, MSB first.
REQ-010 SS_n  output  1  active-low slave select.
REQ-011 busy  output  1  high from the cycle after acceptance until the return to IDLE.
REQ-012 rd_data  output  MEM_WIDTH  byte captured from MISO.
REQ-013 rd_valid  output  1  one-cycle pulse qualifying rd_data.
REQ-014 done  output  1  one-cycle pulse at the end of every transaction.

Function
REQ-015 FSM states: IDLE, SEND, WAIT, RECV, DONE.
REQ-016 IDLE: on start=1, latch {cmd, data_in} into a 10-bit frame register, drive SS_n=0 next cycle, go to SEND; start while busy=1 is ignored.
REQ-017 SEND: shift out the frame MSB first, one bit per cycle, 10 cycles; frame bit 9 (cmd[1]) first, data_in[0] last.
REQ-018 SEND end: cmd=11 -> WAIT; otherwise -> DONE.
REQ-019 WAIT: hold SS_n=0, MOSI=0 for TURNAROUND cycles, then -> RECV.
REQ-020 RECV: sample MISO on 8 consecutive rising edges, MSB first, into a shift register; after the 8th sample -> DONE.
REQ-021 DONE: SS_n=1, MOSI=0, done=1 for one cycle; rd_valid=1 and rd_data updated in this same cycle only if the transaction was RD_DATA; then -> IDLE.
REQ-022 SS_n is high for at least one cycle (DONE) between consecutive frames; back-to-back start in the DONE cycle is ignored, and start in the IDLE cycle that follows is accepted.
REQ-023 rd_data holds its last value until the next RD_DATA completes.
REQ-024 Bit counter is 4 bits; it is reloaded on every state entry and never wraps within a state.
REQ-025 Latency: write or RD_ADDR transaction = 12 cycles from the start sample to done; RD_DATA = 20+TURNAROUND cycles.
REQ-026 Inputs cmd and data_in are don't-care except in the start-accept cycle.

Reset
REQ-027 rst_n low asynchronously forces IDLE, SS_n=1, MOSI=0, busy=0, done=0, rd_valid=0, rd_data=0, all counters and shift registers=0.
REQ-028 Reset mid-frame aborts the transaction with no done or rd_valid pulse; after rst_n deasserts, the next accepted start begins a fresh frame.

Structure
REQ-029 The cmd encoding enum, MEM_WIDTH and the frame length (10) live in shared_pkg; the FSM state enum is local.
REQ-030 One sub-module, spi_shift_reg (parallel-load serial-out and serial-in parallel-out), is instantiated for frame and receive shifting.

Verification
REQ-031 Reset: rst_n=0 for 3 cycles -> SS_n=1, MOSI=0, busy=0, rd_data=0.
REQ-032 WR_ADDR 0x5A: start, cmd=00, data_in=0x5A -> MOSI sequence 0,0,0,1,0,1,1,0,1,0 with SS_n=0 for 10 cycles, done 12 cycles after start, no rd_valid.
REQ-033 RD_DATA: cmd=11, slave model returns 0xC3 after TURNAROUND=2 -> rd_valid pulse with rd_data=0xC3 22 cycles after start.
REQ-034 Busy rejection: second start with cmd=01 issued 4 cycles into a frame -> ignored; exactly one frame on MOSI.
REQ-035 Abort: rst_n pulsed low during the 6th SEND bit -> SS_n=1 immediately, no done; next WR_DATA 0xFF completes normally.
REQ-036 End-to-end: WR_ADDR 0x10, WR_DATA 0xA5, RD_ADDR 0x10, RD_DATA against the SPI slave with RAM -> rd_data=0xA5.
